// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with mid-bit sampling and valid/ack status
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stops; sampled on tick enables.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 serial_data,
  input  logic                 start_rx,
  input  logic                 rx_ack,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DB_M1   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_M1   = 4'(STOP_BITS - 1);
  localparam logic          P_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q, overrun_d;
  logic                 line, detect, sample, complete;

  assign line     = sync2_q;
  assign detect   = tick && (state_q == IDLE) && start_rx && !line;
  assign complete = sample && (state_q == STOP) && (bcnt_q == SB_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      tcnt_q         <= '0;
      bcnt_q         <= '0;
      shift_q        <= '0;
      data_out_q     <= '0;
      par_err_q      <= 1'b0;
      frm_err_q      <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= serial_data;
      sync2_q        <= sync1_q;
      tcnt_q         <= tcnt_d;
      bcnt_q         <= bcnt_d;
      shift_q        <= shift_d;
      data_out_q     <= data_out_d;
      par_err_q      <= par_err_d;
      frm_err_q      <= frm_err_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      overrun_q      <= overrun_d;
    end
  end

  // START samples half a bit after detection so every later sample lands mid-bit.
  always_comb begin
    sample = 1'b0;
    if (tick) begin
      case (state_q)
        START:              sample = (tcnt_q == HALF_M1);
        DATA, PARITY, STOP: sample = (tcnt_q == FULL_M1);
        default:            sample = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    if (tick) begin
      tcnt_d = sample ? '0 : tcnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          tcnt_d = '0;
          bcnt_d = '0;
          if (start_rx && !line) state_d = START;
        end
        START: if (sample) state_d = line ? IDLE : DATA;
        DATA: if (sample) begin
          if (bcnt_q == DB_M1) begin
            bcnt_d  = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
        PARITY: if (sample) state_d = STOP;
        STOP: if (sample) begin
          if (bcnt_q == SB_M1) begin
            bcnt_d  = '0;
            state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d        = shift_q;
    par_err_d      = par_err_q;
    frm_err_d      = frm_err_q;
    data_out_d     = data_out_q;
    data_valid_d   = data_valid_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    overrun_d      = overrun_q;
    if (detect) begin
      par_err_d = 1'b0;
      frm_err_d = 1'b0;
    end
    if (sample) begin
      case (state_q)
        DATA:    shift_d = {line, shift_q[DATA_BITS-1:1]};
        PARITY:  par_err_d = (((^shift_q) ^ line) != P_ODD);
        STOP:    if (!line) frm_err_d = 1'b1;
        default: shift_d = shift_q;
      endcase
    end
    if (rx_ack) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
    // A completing frame takes priority over a coincident acknowledge.
    if (complete) begin
      data_out_d     = shift_q;
      parity_error_d = (PARITY_EN != 0) ? par_err_q : 1'b0;
      frame_error_d  = frm_err_q | !line;
      data_valid_d   = 1'b1;
      overrun_d      = data_valid_q & !rx_ack;
    end
  end

  assign busy         = (state_q != IDLE);
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - self-checking bench for uart_rx_os (defaults: 8E1, x16, tick every 4 clk)
module tb_uart_rx_os;
  logic       clk = 1'b0;
  logic       rst, tick, serial_data, start_rx, rx_ack;
  logic       busy, data_valid, parity_error, frame_error, overrun;
  logic [7:0] data_out;
  int         total = 0;
  int         bad = 0;
  int         tphase = 0;
  logic       m_valid, m_ovr;
  localparam int BITCLK = 64;

  uart_rx_os dut (
    .clk(clk), .rst(rst), .tick(tick), .serial_data(serial_data), .start_rx(start_rx),
    .rx_ack(rx_ack), .busy(busy), .data_out(data_out), .data_valid(data_valid),
    .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tphase == 0);
      tphase = (tphase + 1) % 4;
    end
  end

  task automatic align();
    @(posedge clk);
    while (!tick) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    serial_data = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_data = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    serial_data = p;
    repeat (BITCLK) @(negedge clk);
    serial_data = s;
    repeat (BITCLK) @(negedge clk);
    serial_data = 1'b1;
  endtask

  task automatic ack();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, data_out, data_valid, parity_error, frame_error, overrun} !== 13'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {busy, data_out, data_valid, parity_error, frame_error, overrun});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    align();
    send_frame(8'hA5, 1'b0, 1'b1);
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", data_out); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", data_valid); end
    total++; if (parity_error !== 1'b0 || frame_error !== 1'b0) begin
      bad++; $display("FAIL basic_errors got pe=%b fe=%b exp 0 0", parity_error, frame_error);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
    ack();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL basic_ack got=%b exp=0", data_valid); end
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic test_parity();
    align();
    send_frame(8'hA5, 1'b1, 1'b1);
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL parity_data got=%h exp=a5", data_out); end
    total++; if (parity_error !== 1'b1) begin bad++; $display("FAIL parity_err got=%b exp=1", parity_error); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL parity_valid got=%b exp=1", data_valid); end
    ack();
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic test_framing();
    align();
    send_frame(8'h3C, 1'b0, 1'b0);
    total++; if (frame_error !== 1'b1) begin bad++; $display("FAIL frame_err got=%b exp=1", frame_error); end
    total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL frame_data got=%h exp=3c", data_out); end
    ack();
    repeat (2 * BITCLK) @(negedge clk);
    align();
    send_frame(8'h55, 1'b0, 1'b1);
    total++; if (frame_error !== 1'b0 || data_out !== 8'h55) begin
      bad++; $display("FAIL frame_clean got fe=%b data=%h exp fe=0 data=55", frame_error, data_out);
    end
    ack();
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic test_glitch();
    int busy_clks = 0;
    align();
    serial_data = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (i == 16) serial_data = 1'b1;
      @(negedge clk);
      if (busy) busy_clks++;
    end
    total++; if (busy_clks != 32) begin bad++; $display("FAIL glitch_busy_clks got=%0d exp=32", busy_clks); end
    total++; if (data_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL glitch_state got dv=%b busy=%b exp 0 0", data_valid, busy);
    end
  endtask

  task automatic test_overrun();
    int k = 0;
    align();
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (BITCLK) @(negedge clk);
    align();
    send_frame(8'h81, 1'b0, 1'b1);
    total++; if (data_out !== 8'h81 || overrun !== 1'b1 || data_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_set got data=%h ovr=%b dv=%b exp 81 1 1", data_out, overrun, data_valid);
    end
    ack();
    total++; if (overrun !== 1'b0 || data_valid !== 1'b0) begin
      bad++; $display("FAIL ovr_ack got ovr=%b dv=%b exp 0 0", overrun, data_valid);
    end
    repeat (BITCLK) @(negedge clk);
    align();
    fork
      send_frame(8'h3C, 1'b0, 1'b1);
      begin
        while (!data_valid && k < 2000) begin @(negedge clk); k++; end
      end
    join
    total++; if (k >= 2000 || k < 2) begin bad++; $display("FAIL ovr_latency got=%0d exp=<2000", k); end
    repeat (BITCLK) @(negedge clk);
    align();
    fork
      send_frame(8'h81, 1'b0, 1'b1);
      begin
        repeat (k - 1) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    total++; if (data_out !== 8'h81 || overrun !== 1'b0 || data_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_coincident got data=%h ovr=%b dv=%b exp 81 0 1", data_out, overrun, data_valid);
    end
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hA5;
    align();
    serial_data = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      serial_data = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    serial_data = d[3];
    repeat (24) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    total++;
    if ({busy, data_out, data_valid, parity_error, frame_error, overrun} !== 13'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0", {busy, data_out, data_valid, parity_error, frame_error, overrun});
    end
    serial_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BITCLK) @(negedge clk);
    align();
    send_frame(8'hA5, 1'b0, 1'b1);
    total++; if (data_out !== 8'hA5 || data_valid !== 1'b1 || parity_error !== 1'b0 || frame_error !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got data=%h dv=%b pe=%b fe=%b exp a5 1 0 0", data_out, data_valid, parity_error, frame_error);
    end
    ack();
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       bad_par, bad_stop, p;
    m_valid = data_valid;
    m_ovr   = overrun;
    for (int n = 0; n < 12; n++) begin
      d        = 8'($urandom);
      bad_par  = ($urandom % 4) == 0;
      bad_stop = ($urandom % 5) == 0;
      p        = (^d) ^ bad_par;
      if ($urandom % 2) begin
        ack();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      align();
      send_frame(d, p, !bad_stop);
      m_ovr   = m_valid;
      m_valid = 1'b1;
      total++;
      if (data_out !== d || parity_error !== bad_par || frame_error !== bad_stop ||
          data_valid !== m_valid || overrun !== m_ovr) begin
        bad++;
        $display("FAIL random_%0d got data=%h pe=%b fe=%b dv=%b ovr=%b exp data=%h pe=%b fe=%b dv=%b ovr=%b",
                 n, data_out, parity_error, frame_error, data_valid, overrun, d, bad_par, bad_stop, m_valid, m_ovr);
      end
      repeat (BITCLK) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    serial_data = 1'b1;
    start_rx = 1'b1;
    rx_ack = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
